pid_mc: RTL and testbench
=========================

PID_MC -- requirements
Module: pid_mc

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16, meaning signed data/gain width.
REQ-002 SHALL have parameter Q_BITS, default 13, meaning fractional bits of gains (1.0 = 2^Q_BITS).
REQ-003 SHALL have parameter N_CH, default 4 (power of two, 1..16), meaning channel count; CH_W = max(1,$clog2(N_CH)).
REQ-004 SHALL have port clk, input, 1, sole clock.
REQ-005 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-006 SHALL have port write_enable, input, 1, active-high register write strobe.
REQ-007 SHALL have port iterate_enable, input, 1, level: run channel round-robin while high.
REQ-008 SHALL have port reg_addr, input, D_WIDTH, [2:0] register index, [CH_W+2:3] channel.
REQ-009 SHALL have port reg_data, input, D_WIDTH, write data.
REQ-010 SHALL have port target, input, N_CH*D_WIDTH, packed per-channel setpoints, channel c at [c*D_WIDTH +: D_WIDTH].
REQ-011 SHALL have port measurement, input, N_CH*D_WIDTH, packed per-channel measurements, same packing.
REQ-012 SHALL have port out, output, D_WIDTH, signed control output.
REQ-013 SHALL have port out_ch, output, CH_W, channel of out.
REQ-014 SHALL have port out_valid, output, 1, one-cycle pulse qualifying out/out_ch.

Function
REQ-015 SHALL map register index 0 kp, 1 ki, 2 kd, 3 out_min, 4 out_max, 5 integrator/prev-error clear strobe (data ignored); index 6-7 or channel >= N_CH writes SHALL be ignored.
REQ-016 SHALL take a write effect on the next clock edge; writes SHALL be legal concurrently with iteration.
REQ-017 SHALL run FSM IDLE -> LOAD -> MUL_P -> MUL_I -> MUL_D -> SUM -> OUT; IDLE to LOAD when iterate_enable high; OUT to LOAD (next channel, wrapping N_CH-1 to 0) if iterate_enable high, else IDLE.
REQ-018 SHALL, in LOAD, sample target/measurement/gains/limits of current channel; later changes SHALL not affect that computation.
REQ-019 SHALL assert out_valid during OUT only: 6 cycles after iterate_enable first sampled high, period 6 cycles back-to-back.
REQ-020 SHALL compute err = target - measurement saturated to signed D_WIDTH.
REQ-021 SHALL compute integ_next = integ + err and deriv = err - prev_err, each saturated to signed D_WIDTH.
REQ-022 SHALL use one shared signed D_WIDTH x D_WIDTH multiplier, one term per MUL state; each product arithmetic-shifted right by Q_BITS (floor).
REQ-023 SHALL sum three terms in D_WIDTH+2 bits and clamp to [out_min, out_max]; if out_min > out_max, out SHALL equal out_max.
REQ-024 SHALL update per-channel integ and prev_err in OUT.
REQ-025 SHALL start at channel 0 after reset; dropping iterate_enable SHALL finish current channel, and resumption SHALL continue at the next channel.

Reset
REQ-026 SHALL, on rst high, set state IDLE, channel 0, out 0, out_ch 0, out_valid 0, all gains 0, integ and prev_err 0, out_min most negative, out_max most positive.
REQ-027 SHALL abort any in-flight computation on reset with no out_valid pulse, and SHALL take priority over writes.

Configuration
REQ-028 SHALL compile conditional anti-windup under macro PID_ANTIWINDUP_EN.
REQ-029 SHALL, with PID_ANTIWINDUP_EN defined, keep integ unchanged when output is clamped high with err > 0 or clamped low with err < 0.
REQ-030 SHALL, without PID_ANTIWINDUP_EN, always update integ per REQ-021.

Structure
REQ-031 SHALL place FSM state enum, register index constants and the saturation function in package pid_pkg.
REQ-032 SHALL put the shift/sum/clamp datapath in sub-module pid_sat_sum; per-channel state in arrays indexed by channel.

Verification
REQ-033 SHALL cover proportional: N_CH=4, ch0 kp=4096, target 1000, measurement 0 -> first out_valid at cycle 6, out=500, out_ch=0.
REQ-034 SHALL cover integral: ch0 ki=8192, err 100 constant -> ch0 outputs 100, 200, 300.
REQ-035 SHALL cover clamp/anti-windup: ki=8192, out_max=250, err 100 for 4 iterations then -100 -> outputs 100,200,250,250 then 100 with PID_ANTIWINDUP_EN, 250 without.
REQ-036 SHALL cover derivative: kd=8192, err 0 then 50 then 50 -> outputs 0, 50, 0.
REQ-037 SHALL cover round-robin and reset: distinct kp per channel -> out_ch 0,1,2,3,0 every 6 cycles; rst asserted in MUL_I -> no pulse, next out_ch 0 with integrators zero.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared FSM states, register indices and signed saturation helper for pid_mc
package pid_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUM, OUT} state_t;
  localparam logic [2:0] REG_KP = 3'd0;
  localparam logic [2:0] REG_KI = 3'd1;
  localparam logic [2:0] REG_KD = 3'd2;
  localparam logic [2:0] REG_MIN = 3'd3;
  localparam logic [2:0] REG_MAX = 3'd4;
  localparam logic [2:0] REG_CLR = 3'd5;
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction
endpackage

// File: rtl/pid_sat_sum.sv
// pid_sat_sum: floor-shifts three Q-format products, sums in D_WIDTH+2 bits and clamps to [mn_i, mx_i] (mx_i wins if mn_i > mx_i); hi_o/lo_o flag clamping
module pid_sat_sum #(
  parameter int D_WIDTH = 16,
  parameter int Q_BITS = 13
) (
  input  logic signed [2*D_WIDTH-1:0] p_i,
  input  logic signed [2*D_WIDTH-1:0] i_i,
  input  logic signed [2*D_WIDTH-1:0] d_i,
  input  logic signed [D_WIDTH-1:0]   mn_i,
  input  logic signed [D_WIDTH-1:0]   mx_i,
  output logic signed [D_WIDTH-1:0]   y_o,
  output logic                        hi_o,
  output logic                        lo_o
);
  localparam int S = D_WIDTH + 2;
  logic signed [2*D_WIDTH-1:0] ps, is, ds;
  logic signed [S-1:0] sum, smn, smx;
  logic unused_ok;
  assign ps = p_i >>> Q_BITS;
  assign is = i_i >>> Q_BITS;
  assign ds = d_i >>> Q_BITS;
  assign sum = S'(ps) + S'(is) + S'(ds);
  assign smn = S'(mn_i);
  assign smx = S'(mx_i);
  assign hi_o = sum > smx;
  assign lo_o = !hi_o && (sum < smn);
  assign y_o = (mn_i > mx_i || hi_o) ? mx_i : lo_o ? mn_i : D_WIDTH'(sum);
  assign unused_ok = ^{ps[2*D_WIDTH-1:S], is[2*D_WIDTH-1:S], ds[2*D_WIDTH-1:S]};
endmodule

// File: rtl/pid_mc.sv
// pid_mc: multi-channel round-robin PID with one shared multiplier (LOAD,MUL_P,MUL_I,MUL_D,SUM,OUT); ports clk, rst, write_enable/reg_addr/reg_data register writes, iterate_enable, packed target/measurement, out/out_ch/out_valid; anti-windup when PID_ANTIWINDUP_EN is defined
module pid_mc
  import pid_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int Q_BITS = 13,
  parameter int N_CH = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_enable,
  input  logic                     iterate_enable,
  input  logic [D_WIDTH-1:0]       reg_addr,
  input  logic [D_WIDTH-1:0]       reg_data,
  input  logic [N_CH*D_WIDTH-1:0]  target,
  input  logic [N_CH*D_WIDTH-1:0]  measurement,
  output logic [D_WIDTH-1:0]       out,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid
);
  typedef logic signed [D_WIDTH-1:0] word_t;
  localparam word_t W_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam word_t W_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
  state_t state_q, state_d;
  logic [CH_W-1:0] ch_q, out_ch_q, wch;
  word_t kp_q[N_CH], ki_q[N_CH], kd_q[N_CH], mn_q[N_CH], mx_q[N_CH], integ_q[N_CH], prev_q[N_CH];
  word_t kp_l, ki_l, kd_l, mn_l, mx_l, err_l, in_l, dv_l, out_q, tgt, meas, e, ma, mb, y;
  logic signed [D_WIDTH:0] diff, isum, dsum;
  logic signed [2*D_WIDTH-1:0] prod, p_q, i_q, d_q;
  logic out_valid_q, hi_q, lo_q, hi, lo, aw_hold, wok, unused_ok;
  logic [2:0] widx;
  assign tgt = target[ch_q*D_WIDTH +: D_WIDTH];
  assign meas = measurement[ch_q*D_WIDTH +: D_WIDTH];
  assign diff = tgt - meas;
  assign e = word_t'(sat_s(64'(diff), D_WIDTH));
  assign isum = integ_q[ch_q] + e;
  assign dsum = e - prev_q[ch_q];
  assign ma = (state_q == MUL_P) ? kp_l : (state_q == MUL_I) ? ki_l : kd_l;
  assign mb = (state_q == MUL_P) ? err_l : (state_q == MUL_I) ? in_l : dv_l;
  assign prod = ma * mb;
  assign widx = reg_addr[2:0];
  assign wch = reg_addr[CH_W+2:3];
  assign wok = write_enable && (32'(wch) < N_CH);
  assign unused_ok = ^reg_addr[D_WIDTH-1:CH_W+3];
  assign out = out_q;
  assign out_ch = out_ch_q;
  assign out_valid = out_valid_q;
`ifdef PID_ANTIWINDUP_EN
  assign aw_hold = (hi_q && err_l > 0) || (lo_q && err_l < 0);
`else
  logic unused_aw;
  assign unused_aw = hi_q ^ lo_q;
  assign aw_hold = 1'b0;
`endif
  pid_sat_sum #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_sum (
    .p_i(p_q), .i_i(i_q), .d_i(d_q), .mn_i(mn_l), .mx_i(mx_l), .y_o(y), .hi_o(hi), .lo_o(lo)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = iterate_enable ? LOAD : IDLE;
      LOAD:    state_d = MUL_P;
      MUL_P:   state_d = MUL_I;
      MUL_I:   state_d = MUL_D;
      MUL_D:   state_d = SUM;
      SUM:     state_d = OUT;
      OUT:     state_d = iterate_enable ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      out_q <= '0;
      out_ch_q <= '0;
      out_valid_q <= 1'b0;
      {kp_l, ki_l, kd_l, err_l, in_l, dv_l} <= '0;
      mn_l <= W_MIN;
      mx_l <= W_MAX;
      {p_q, i_q, d_q} <= '0;
      {hi_q, lo_q} <= '0;
      for (int c = 0; c < N_CH; c++) begin
        {kp_q[c], ki_q[c], kd_q[c], integ_q[c], prev_q[c]} <= '0;
        mn_q[c] <= W_MIN;
        mx_q[c] <= W_MAX;
      end
    end else begin
      state_q <= state_d;
      out_valid_q <= state_q == SUM;
      if (state_q == LOAD) begin
        err_l <= e;
        in_l <= word_t'(sat_s(64'(isum), D_WIDTH));
        dv_l <= word_t'(sat_s(64'(dsum), D_WIDTH));
        kp_l <= kp_q[ch_q];
        ki_l <= ki_q[ch_q];
        kd_l <= kd_q[ch_q];
        mn_l <= mn_q[ch_q];
        mx_l <= mx_q[ch_q];
      end
      if (state_q == MUL_P) p_q <= prod;
      if (state_q == MUL_I) i_q <= prod;
      if (state_q == MUL_D) d_q <= prod;
      if (state_q == SUM) begin
        out_q <= y;
        out_ch_q <= ch_q;
        hi_q <= hi;
        lo_q <= lo;
      end
      if (state_q == OUT) begin
        integ_q[ch_q] <= aw_hold ? integ_q[ch_q] : in_l;
        prev_q[ch_q] <= err_l;
        ch_q <= (32'(ch_q) == N_CH - 1) ? '0 : ch_q + 1'b1;
      end
      // a clear landing on the same edge as the OUT update wins
      if (wok) begin
        case (widx)
          REG_KP:  kp_q[wch] <= reg_data;
          REG_KI:  ki_q[wch] <= reg_data;
          REG_KD:  kd_q[wch] <= reg_data;
          REG_MIN: mn_q[wch] <= reg_data;
          REG_MAX: mx_q[wch] <= reg_data;
          REG_CLR: begin
            integ_q[wch] <= '0;
            prev_q[wch] <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pid_mc.sv
// tb_pid_mc: directed self-checking bench for pid_mc with N_CH=4
module tb_pid_mc;
`ifdef PID_ANTIWINDUP_EN
  localparam int AW_EXP = 100;
`else
  localparam int AW_EXP = 250;
`endif
  logic clk = 1'b0, rst = 1'b1, write_enable = 1'b0, iterate_enable = 1'b0;
  logic [15:0] reg_addr = '0, reg_data = '0;
  logic [63:0] target = '0, measurement = '0;
  logic [15:0] out;
  logic [1:0] out_ch;
  logic out_valid;
  int errors = 0, checks = 0;
  int cyc, pulses;
  logic signed [15:0] v;
  always #5 clk = ~clk;
  pid_mc #(.D_WIDTH(16), .Q_BITS(13), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .iterate_enable(iterate_enable),
    .reg_addr(reg_addr), .reg_data(reg_data), .target(target), .measurement(measurement),
    .out(out), .out_ch(out_ch), .out_valid(out_valid)
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wr(input int idx, input int ch, input int data);
    reg_addr = {11'd0, 2'(ch), 3'(idx)};
    reg_data = 16'(data);
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask
  task automatic set_t(input int ch, input int val);
    target[ch*16 +: 16] = 16'(val);
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    iterate_enable = 1'b0;
    write_enable = 1'b0;
    target = '0;
    measurement = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
    chk("pulse_seen", out_valid, 1);
  endtask
  task automatic wait_ch0(output logic signed [15:0] val);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ch == 2'd0) && n < 60);
    chk("ch0_pulse_seen", out_valid && out_ch == 2'd0, 1);
    val = out;
  endtask
  initial begin
    @(negedge clk);
    reset_dut();
    chk("rst_out", $signed(out), 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_valid", out_valid, 0);
    wr(0, 0, 4096);
    set_t(0, 1000);
    iterate_enable = 1'b1;
    wait_pulse(cyc);
    chk("p_latency", cyc, 6);
    chk("p_out", $signed(out), 500);
    chk("p_ch", out_ch, 0);
    @(negedge clk);
    chk("p_pulse_width", out_valid, 0);
    reset_dut();
    wr(1, 0, 8192);
    set_t(0, 100);
    iterate_enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_ch0(v);
      chk("i_out", v, 100 * i);
    end
    wr(5, 0, 0);
    wait_ch0(v);
    chk("i_after_clear", v, 100);
    reset_dut();
    wr(1, 0, 8192);
    wr(4, 0, 250);
    set_t(0, 100);
    iterate_enable = 1'b1;
    wait_ch0(v);
    chk("aw_1", v, 100);
    wait_ch0(v);
    chk("aw_2", v, 200);
    wait_ch0(v);
    chk("aw_3", v, 250);
    wait_ch0(v);
    chk("aw_4", v, 250);
    set_t(0, -100);
    wait_ch0(v);
    chk("aw_neg", v, AW_EXP);
    reset_dut();
    wr(2, 0, 8192);
    iterate_enable = 1'b1;
    wait_ch0(v);
    chk("d_zero", v, 0);
    set_t(0, 50);
    wait_ch0(v);
    chk("d_step", v, 50);
    wait_ch0(v);
    chk("d_flat", v, 0);
    reset_dut();
    wr(0, 0, 8192);
    wr(3, 0, 300);
    wr(4, 0, 200);
    set_t(0, 100);
    iterate_enable = 1'b1;
    wait_ch0(v);
    chk("inv_limits", v, 200);
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      wr(0, c, 2048 * (c + 1));
      set_t(c, 400);
    end
    iterate_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_pulse(cyc);
      chk("rr_gap", cyc, 6);
      chk("rr_ch", out_ch, k % 4);
      chk("rr_out", $signed(out), 100 * ((k % 4) + 1));
    end
    reset_dut();
    wr(1, 0, 8192);
    set_t(0, 100);
    iterate_enable = 1'b1;
    wait_ch0(v);
    chk("mr_first", v, 100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("mr_no_pulse", pulses, 0);
    chk("mr_out_cleared", $signed(out), 0);
    iterate_enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    wr(1, 0, 8192);
    iterate_enable = 1'b1;
    wait_pulse(cyc);
    chk("mr_latency", cyc, 6);
    chk("mr_ch", out_ch, 0);
    chk("mr_integ_zero", $signed(out), 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
